// File: rtl/hbm_bench_pkg.sv
// Shared AXI encodings and FSM state types for the HBM benchmark blocks.
package hbm_bench_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM: byte-enable write port, registered read port, read-first.
module sdp_ram_be #(
  parameter int DATA_WIDTH = 256,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(MEM_WORDS)-1:0]  waddr,
  input  logic [DATA_WIDTH/8-1:0]       wbe,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          re,
  input  logic [$clog2(MEM_WORDS)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int BE = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Non-blocking read and write in one process gives old data on a same-word collision.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
    for (int b = 0; b < BE; b++) begin
      if (we && wbe[b]) begin
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3 responder backed by on-chip RAM; one outstanding burst per direction.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits on ready, and payload is held stable while valid is high and ready low.
module axi_mem_slave
  import hbm_bench_pkg::*;
#(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int USER_WIDTH = 5,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [1:0]              awburst,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [USER_WIDTH-1:0]   awuser,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic [USER_WIDTH-1:0]   wuser,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic [USER_WIDTH-1:0]   buser,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [1:0]              arburst,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [USER_WIDTH-1:0]   aruser,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic [USER_WIDTH-1:0]   ruser,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [1:0]              wr_state_dbg,
  output logic                    rd_state_dbg
);

  localparam int              BYTE_LSB   = $clog2(DATA_WIDTH / 8);
  localparam int              IDX_W      = $clog2(MEM_WORDS);
  localparam logic [2:0]      SIZE_LEGAL = 3'(BYTE_LSB);

  // Byte offset and bits above the RAM depth alias; wuser has no storage.
  logic unused_sideband;
  assign unused_sideband = ^{wuser, awaddr, araddr};

  // ---------------------------------------------------------------- write side
  wr_state_t         wr_state, wr_next;
  logic [IDX_W-1:0]  w_idx;
  logic [3:0]        w_len, w_cnt;
  logic              w_err, w_bad;
  logic              aw_hs, w_hs, w_beat_last, ram_we;

  always_comb begin
    wr_next     = wr_state;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    ram_we      = 1'b0;
    w_beat_last = (w_cnt == w_len);
    case (wr_state)
      W_IDLE: begin
        if (awvalid && awready) begin
          aw_hs   = 1'b1;
          wr_next = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready) begin
          w_hs   = 1'b1;
          ram_we = !w_err;
          if (w_beat_last) wr_next = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid && bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Ready/valid flags are registered copies of the next state so they are 0 in reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      w_idx    <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_err    <= 1'b0;
      w_bad    <= 1'b0;
      bid      <= '0;
      buser    <= '0;
      bresp    <= AXI_RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      awready  <= (wr_next == W_IDLE);
      wready   <= (wr_next == W_DATA);
      bvalid   <= (wr_next == W_RESP);
      if (aw_hs) begin
        w_idx <= awaddr[BYTE_LSB +: IDX_W];
        w_len <= awlen;
        w_cnt <= '0;
        w_err <= !((awburst == AXI_BURST_INCR) && (awsize == SIZE_LEGAL));
        w_bad <= 1'b0;
        bid   <= awid;
        buser <= awuser;
      end
      if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 4'd1;
        // wlast must coincide with the counted final beat; the count decides the end.
        if (wlast != w_beat_last) w_bad <= 1'b1;
        if (w_beat_last) begin
          bresp <= (w_err || w_bad || !wlast) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
      end
    end
  end

  // ----------------------------------------------------------------- read side
  rd_state_t             rd_state, rd_next;
  logic [IDX_W-1:0]      r_idx;
  logic [3:0]            r_len, r_cnt;
  logic                  r_err, r_issue_done;
  logic                  ar_hs, r_issue, r_push, r_pop;
  logic                  pend_valid, pend_last;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  fifo_wp, fifo_rp;
  logic [1:0]            fifo_cnt;
  logic [2:0]            occ;

  assign rvalid = (fifo_cnt != 2'd0);
  assign rdata  = fifo_data[fifo_rp];
  assign rlast  = fifo_last[fifo_rp];
  assign r_pop  = rvalid && rready;
  assign r_push = pend_valid;
  // Entries that will be in the buffer once this cycle's push/pop settle.
  assign occ    = {1'b0, fifo_cnt} + {2'b0, pend_valid} - {2'b0, r_pop};

  always_comb begin
    rd_next = rd_state;
    ar_hs   = 1'b0;
    r_issue = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (arvalid && arready) begin
          ar_hs   = 1'b1;
          rd_next = R_DATA;
        end
      end
      R_DATA: begin
        if (!r_issue_done && (occ < 3'd2)) r_issue = 1'b1;
        if (r_pop && rlast) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rd_state     <= R_IDLE;
      arready      <= 1'b0;
      r_idx        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_issue_done <= 1'b0;
      rid          <= '0;
      ruser        <= '0;
      rresp        <= AXI_RESP_OKAY;
      pend_valid   <= 1'b0;
      pend_last    <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      fifo_wp      <= 1'b0;
      fifo_rp      <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      rd_state   <= rd_next;
      arready    <= (rd_next == R_IDLE);
      pend_valid <= r_issue;
      if (ar_hs) begin
        r_idx        <= araddr[BYTE_LSB +: IDX_W];
        r_len        <= arlen;
        r_cnt        <= '0;
        r_issue_done <= 1'b0;
        r_err        <= !((arburst == AXI_BURST_INCR) && (arsize == SIZE_LEGAL));
        rresp        <= ((arburst == AXI_BURST_INCR) && (arsize == SIZE_LEGAL)) ?
                        AXI_RESP_OKAY : AXI_RESP_SLVERR;
        rid          <= arid;
        ruser        <= aruser;
      end
      if (r_issue) begin
        r_idx     <= r_idx + 1'b1;
        r_cnt     <= r_cnt + 4'd1;
        pend_last <= (r_cnt == r_len);
        if (r_cnt == r_len) r_issue_done <= 1'b1;
      end
      if (r_push) begin
        fifo_data[fifo_wp] <= r_err ? '0 : ram_rdata;
        fifo_last[fifo_wp] <= pend_last;
        fifo_wp            <= ~fifo_wp;
      end
      if (r_pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, r_push} - {1'b0, r_pop};
    end
  end

  sdp_ram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_idx),
    .wbe   (wstrb),
    .wdata (wdata),
    .re    (r_issue),
    .raddr (r_idx),
    .rdata (ram_rdata)
  );

  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: write/read bursts, wrap, strobes, error bursts, reset abort.
module tb_axi_mem_slave;

  localparam int DW = 256;
  localparam int AW = 33;

  logic            clk;
  logic            arstn;
  logic [AW-1:0]   awaddr, araddr;
  logic [1:0]      awburst, arburst;
  logic [3:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [5:0]      awid, arid, bid, rid;
  logic [4:0]      awuser, aruser, wuser, buser, ruser;
  logic            awvalid, awready, arvalid, arready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready;
  logic            rlast, rvalid, rready;
  logic [1:0]      wr_state_dbg;
  logic            rd_state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0]   exp_q [$];
  logic [DW-1:0]   wbuf [16];
  logic [DW/8-1:0] sbuf [16];

  axi_mem_slave dut (
    .clk(clk), .arstn(arstn),
    .awaddr(awaddr), .awburst(awburst), .awlen(awlen), .awsize(awsize),
    .awid(awid), .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arburst(arburst), .arlen(arlen), .arsize(arsize),
    .arid(arid), .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready),
    .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_write(input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [5:0] id, input logic [4:0] user,
                          input int last_at, input logic [1:0] exp_resp);
    int t;
    int ilen;
    ilen    = int'(len);
    awaddr  = addr; awlen = len; awburst = burst; awsize = size;
    awid    = id;   awuser = user; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    check("aw_ready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    check("wready_lat", wready, 1);
    for (int i = 0; i <= ilen; i++) begin
      wdata  = wbuf[i];
      wstrb  = sbuf[i];
      wlast  = (i == last_at);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      check("w_ready", wready, 1);
      @(negedge clk);
      if (i < ilen) check("bvalid_early", bvalid, 0);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("bvalid_lat", bvalid, 1);
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    check("bresp", bresp, exp_resp);
    check("bid", bid, id);
    check("buser", buser, user);
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_clr", bvalid, 0);
    check("awready_b2b", awready, 1);
  endtask

  // Expected beats come from exp_q; abort_at >= 0 asserts reset once that many beats are out.
  task automatic do_read(input logic [AW-1:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [5:0] id,
                         input logic [4:0] user, input int throttle,
                         input logic [1:0] exp_resp, input int abort_at);
    int t;
    int lat;
    int beat;
    int cyc;
    int ilen;
    ilen    = int'(len);
    araddr  = addr; arlen = len; arburst = 2'b01; arsize = size;
    arid    = id;   aruser = user; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    check("ar_ready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
    check("r_first_lat", lat, 2);
    beat = 0;
    cyc  = 0;
    while (beat <= ilen && cyc < 400) begin
      if (abort_at >= 0 && beat == abort_at) begin
        exp_q.delete();
        rready = 1'b0;
        arstn  = 1'b0;
        #1;
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rlast", rlast, 0);
        check("rst_arready", arready, 0);
        return;
      end
      rready = (throttle == 0) ? 1'b1 : ($urandom_range(99) >= throttle);
      if (rvalid) begin
        if (rready) begin
          check("rdata", rdata, exp_q.pop_front());
          check("rlast", rlast, (beat == ilen));
          check("rresp", rresp, exp_resp);
          check("rid", rid, id);
          check("ruser", ruser, user);
          beat++;
        end else begin
          check("rdata_stall", rdata, exp_q[0]);
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    check("r_beats", beat, ilen + 1);
    if (throttle == 0) check("r_cycles", cyc, ilen + 1);
    check("rvalid_end", rvalid, 0);
    check("arready_b2b", arready, 1);
  endtask

  // stimulus
  initial begin
    arstn   = 1'b0;
    awaddr  = '0; awburst = 2'b01; awlen = '0; awsize = 3'd5; awid = '0; awuser = '0;
    awvalid = 1'b0;
    araddr  = '0; arburst = 2'b01; arlen = '0; arsize = 3'd5; arid = '0; aruser = '0;
    arvalid = 1'b0;
    wdata   = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0;
    bready  = 1'b0; rready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bresp", bresp, 0);
    check("rst_bid", bid, 0);
    check("rst_rid", rid, 0);
    check("rst_wstate", wr_state_dbg, 0);
    arstn = 1'b1;
    @(negedge clk);
    check("idle_awready", awready, 1);
    check("idle_arready", arready, 1);

    // single beat write then read
    wbuf[0] = {32{8'hA5}};
    sbuf[0] = '1;
    do_write(33'h40, 4'd0, 2'b01, 3'd5, 6'h11, 5'h03, 0, 2'b00);
    exp_q.push_back({32{8'hA5}});
    do_read(33'h40, 4'd0, 3'd5, 6'h22, 5'h04, 0, 2'b00, -1);

    // 16-beat burst starting at word 1016 wraps to word 7
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = '0;
      wbuf[i][31:0] = i;
      sbuf[i] = '1;
    end
    do_write(33'h7F00, 4'd15, 2'b01, 3'd5, 6'h05, 5'h1F, 15, 2'b00);
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'(i));
    do_read(33'h7F00, 4'd15, 3'd5, 6'h06, 5'h01, 0, 2'b00, -1);
    exp_q.push_back(DW'(15));
    do_read(33'hE0, 4'd0, 3'd5, 6'h07, 5'h02, 0, 2'b00, -1);

    // throttled readback of the same burst
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'(i));
    do_read(33'h7F00, 4'd15, 3'd5, 6'h08, 5'h05, 30, 2'b00, -1);

    // byte strobes
    wbuf[0] = '1;
    sbuf[0] = '1;
    do_write(33'h200, 4'd0, 2'b01, 3'd5, 6'h09, 5'h00, 0, 2'b00);
    wbuf[0] = '0;
    sbuf[0] = 32'h1;
    do_write(33'h200, 4'd0, 2'b01, 3'd5, 6'h0A, 5'h00, 0, 2'b00);
    exp_q.push_back({{31{8'hFF}}, 8'h00});
    do_read(33'h200, 4'd0, 3'd5, 6'h0B, 5'h00, 0, 2'b00, -1);

    // WRAP burst type is rejected: SLVERR and memory untouched
    wbuf[0] = DW'(32'h1234);
    sbuf[0] = '1;
    do_write(33'h200, 4'd0, 2'b10, 3'd5, 6'h0C, 5'h0C, 0, 2'b10);
    exp_q.push_back({{31{8'hFF}}, 8'h00});
    do_read(33'h200, 4'd0, 3'd5, 6'h0D, 5'h00, 0, 2'b00, -1);

    // narrow read size: four zero beats with SLVERR
    for (int i = 0; i < 4; i++) exp_q.push_back('0);
    do_read(33'h7F00, 4'd3, 3'd0, 6'h0E, 5'h0E, 0, 2'b10, -1);

    // wlast on beat 2 of a 4-beat burst
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = DW'(100 + i);
      sbuf[i] = '1;
    end
    do_write(33'h400, 4'd3, 2'b01, 3'd5, 6'h0F, 5'h10, 1, 2'b10);

    // reset during beat 5 of a read, then normal traffic resumes
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'(i));
    do_read(33'h7F00, 4'd15, 3'd5, 6'h12, 5'h12, 0, 2'b00, 5);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    check("post_rst_arready", arready, 1);
    check("post_rst_awready", awready, 1);
    check("post_rst_rvalid", rvalid, 0);
    exp_q.push_back(DW'(15));
    do_read(33'hE0, 4'd0, 3'd5, 6'h13, 5'h13, 0, 2'b00, -1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
